// File: rtl/ga_pkg.sv
// Shared GA datapath types: crossover mode encodings, mask-generator FSM states and
// the 16-bit LFSR polynomial plus default seed.
package ga_pkg;

    typedef enum logic [1:0] {
        XO_UNIFORM = 2'd0,
        XO_SINGLE  = 2'd1,
        XO_TWO     = 2'd2,
        XO_PASS    = 2'd3
    } xo_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } xo_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Fibonacci LFSR, shift-left with feedback into bit 0; one step per step_i cycle.
// Load has priority over step, and a zero seed is replaced by 1 so the register never locks up.
module ga_lfsr16
    import ga_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
        end else if (step_i) begin
            state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/crossover_mask_gen.sv
// GENES-wide crossover mask generator (uniform / single / two-point / pass), one random draw per cycle.
// Mask appears 1 + draws cycles after accept and is held until mask_ready; new requests wait on busy.
module crossover_mask_gen
    import ga_pkg::*;
#(
    parameter int          GENES  = 8,
    parameter int          PROB_W = 4,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              bias,
    input  logic [PROB_W-1:0] prob,
    input  logic              rand_ext,
    input  logic [PROB_W-1:0] rand_in,
    input  logic              seed_load,
    input  logic [15:0]       seed_in,
    output logic              busy,
    output logic              mask_valid,
    input  logic              mask_ready,
    output logic [GENES-1:0]  mask
);

    localparam int IDX_W = $clog2(GENES);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_GENES = CNT_W'(GENES);
    localparam logic [CNT_W-1:0] CNT_ULAST = CNT_W'(GENES - 1);

    xo_state_t         state_q, state_d;
    xo_mode_t          mode_q;
    logic              bias_q;
    logic [PROB_W-1:0] prob_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gate_q, gate_d;
    logic [IDX_W-1:0]  pa_q, pa_d;
    logic [GENES-1:0]  raw_q, raw_d;
    logic [GENES-1:0]  mask_q, mask_d;

    logic              accept;
    logic              last_draw;
    logic [15:0]       lfsr_state;
    logic [PROB_W-1:0] r;
    logic              hit;
    logic [CNT_W-1:0]  idx, lo, hi;

    // Bits lo..hi-1 set; hi may equal GENES, hence the extra counter bit.
    function automatic logic [GENES-1:0] span(input logic [CNT_W-1:0] from_i,
                                              input logic [CNT_W-1:0] to_i);
        logic [GENES-1:0] res;
        for (int i = 0; i < GENES; i++) begin
            res[i] = (CNT_W'(i) >= from_i) && (CNT_W'(i) < to_i);
        end
        return res;
    endfunction

    ga_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (state_q == ST_IDLE && !start && seed_load),
        .seed_i  (seed_in),
        .step_i  (state_q == ST_DRAW && !rand_ext),
        .state_o (lfsr_state)
    );

    generate
        if (PROB_W < 16) begin : g_lfsr_spare
            logic unused_lfsr_bits;
            assign unused_lfsr_bits = ^lfsr_state[15:PROB_W];
        end
    endgenerate

    assign accept = (state_q == ST_IDLE) && start;
    assign r      = rand_ext ? rand_in : lfsr_state[PROB_W-1:0];
    assign hit    = prob_q > r;
    assign idx    = {1'b0, r[IDX_W-1:0]};
    assign lo     = ({1'b0, pa_q} < idx) ? {1'b0, pa_q} : idx;
    assign hi     = ({1'b0, pa_q} < idx) ? idx : {1'b0, pa_q};

    always_comb begin
        case (mode_q)
            XO_UNIFORM: last_draw = (cnt_q == CNT_ULAST);
            XO_SINGLE:  last_draw = (cnt_q == CNT_ONE);
            XO_TWO:     last_draw = (cnt_q == CNT_TWO);
            default:    last_draw = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (xo_mode_t'(mode) == XO_PASS) ? ST_DONE : ST_DRAW;
            ST_DRAW: if (last_draw) state_d = ST_DONE;
            ST_DONE: if (mask_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q != ST_IDLE);
        mask_valid = (state_q == ST_DONE);
    end

    // Draw datapath: the final draw folds straight into the registered mask.
    always_comb begin
        cnt_d  = cnt_q;
        gate_d = gate_q;
        pa_d   = pa_q;
        raw_d  = raw_q;
        mask_d = mask_q;
        if (accept) begin
            cnt_d  = CNT_ZERO;
            gate_d = 1'b0;
            pa_d   = '0;
            raw_d  = '0;
            if (xo_mode_t'(mode) == XO_PASS) mask_d = {GENES{bias}};
        end else if (state_q == ST_DRAW) begin
            cnt_d = cnt_q + CNT_ONE;
            case (mode_q)
                XO_UNIFORM: raw_d[cnt_q[IDX_W-1:0]] = hit;
                XO_SINGLE: begin
                    if (cnt_q == CNT_ZERO) gate_d = hit;
                    else                   raw_d  = gate_q ? span(idx, CNT_GENES) : '0;
                end
                XO_TWO: begin
                    if (cnt_q == CNT_ZERO)     gate_d = hit;
                    else if (cnt_q == CNT_ONE) pa_d   = r[IDX_W-1:0];
                    else                       raw_d  = gate_q ? span(lo, hi) : '0;
                end
                default: raw_d = '0;
            endcase
            if (last_draw) mask_d = raw_d ^ {GENES{bias_q}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= XO_UNIFORM;
            bias_q <= 1'b0;
            prob_q <= '0;
            cnt_q  <= '0;
            gate_q <= 1'b0;
            pa_q   <= '0;
            raw_q  <= '0;
            mask_q <= '0;
        end else begin
            if (accept) begin
                mode_q <= xo_mode_t'(mode);
                bias_q <= bias;
                prob_q <= prob;
            end
            cnt_q  <= cnt_d;
            gate_q <= gate_d;
            pa_q   <= pa_d;
            raw_q  <= raw_d;
            mask_q <= mask_d;
        end
    end

    assign mask = mask_q;

endmodule

// File: tb/tb_crossover_mask_gen.sv
// Randomised and directed checks of crossover_mask_gen against a behavioural mask model.
module tb_crossover_mask_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        bias = 1'b0;
    logic [3:0]  prob = 4'd0;
    logic        rand_ext = 1'b0;
    logic [3:0]  rand_in = 4'd0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        busy;
    logic        mask_valid;
    logic        mask_ready = 1'b0;
    logic [7:0]  mask;

    crossover_mask_gen #(.GENES(8), .PROB_W(4), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .bias       (bias),
        .prob       (prob),
        .rand_ext   (rand_ext),
        .rand_in    (rand_in),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .busy       (busy),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] mlfsr = 16'hACE1;
    int          drw [8];
    bit          noise = 1'b0;
    logic [7:0]  got;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int ndraws(input int m);
        case (m)
            0: return 8;
            1: return 2;
            2: return 3;
            default: return 0;
        endcase
    endfunction

    // Mask from the crossover rules, using draws already in drw[].
    function automatic logic [7:0] ref_mask(input int m, input bit b, input int p);
        logic [7:0] raw = 8'h00;
        int a, c, lo, hi;
        if (m == 0) begin
            for (int g = 0; g < 8; g++) raw[g] = (p > drw[g]);
        end else if (m == 1 && p > drw[0]) begin
            for (int i = 0; i < 8; i++) raw[i] = (i >= drw[1] % 8);
        end else if (m == 2 && p > drw[0]) begin
            a  = drw[1] % 8;
            c  = drw[2] % 8;
            lo = (a < c) ? a : c;
            hi = (a < c) ? c : a;
            for (int i = 0; i < 8; i++) raw[i] = (i >= lo) && (i < hi);
        end
        return b ? ~raw : raw;
    endfunction

    task automatic issue(input int m, input bit b, input int p, input bit ext, output logic [7:0] res);
        int nd = ndraws(m);
        int lat;
        if (!ext) begin
            for (int k = 0; k < nd; k++) begin
                drw[k] = int'(mlfsr[3:0]);
                mlfsr  = lfsr_next(mlfsr);
            end
        end
        @(negedge clk);
        start     = 1'b1;
        mode      = m[1:0];
        bias      = b;
        prob      = p[3:0];
        rand_ext  = ext;
        seed_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        seed_in   = 16'($urandom);
        @(posedge clk);
        lat = 1;
        for (int guard = 0; guard < 40; guard++) begin
            @(negedge clk);
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            seed_load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (lat == 1) check_eq("busy_after_accept", 32'(busy), 32'd1);
            if (mask_valid) break;
            if (lat - 1 < 8) rand_in = drw[lat-1][3:0];
            @(posedge clk);
            lat++;
        end
        start     = 1'b0;
        seed_load = 1'b0;
        check_eq("latency", 32'(lat), 32'(nd + 1));
        check_eq("mask", 32'(mask), 32'(ref_mask(m, b, p)));
        res = mask;
    endtask

    task automatic handshake(input int delay, input logic [7:0] held);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("stall_valid", 32'(mask_valid), 32'd1);
            check_eq("stall_mask", 32'(mask), 32'(held));
        end
        mask_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mask_ready = 1'b0;
        check_eq("post_hs_busy", 32'(busy), 32'd0);
        check_eq("post_hs_valid", 32'(mask_valid), 32'd0);
        check_eq("post_hs_mask", 32'(mask), 32'(held));
    endtask

    initial begin
        int m, p;
        bit b, ext;

        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(mask_valid), 32'd0);
        check_eq("rst_mask", 32'(mask), 32'd0);
        check_eq("rst_lfsr", 32'(dut.u_lfsr.state_o), 32'hACE1);
        @(negedge clk);
        rst_n = 1'b1;

        // Uniform, external random
        drw = '{0, 9, 7, 8, 15, 1, 8, 3};
        issue(0, 1'b0, 8, 1'b1, got);
        check_eq("uni_const", 32'(got), 32'hA5);
        handshake(0, got);

        // Reset during the fourth uniform draw
        @(negedge clk);
        start = 1'b1; mode = 2'd0; bias = 1'b0; prob = 4'd8; rand_ext = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start   = 1'b0;
            rand_in = 4'(k);
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_valid", 32'(mask_valid), 32'd0);
        check_eq("midrst_mask", 32'(mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mlfsr = 16'hACE1;
        drw = '{3, 12, 5, 15, 0, 7, 9, 2};
        issue(0, 1'b1, 7, 1'b1, got);
        handshake(1, got);

        // Single-point
        drw = '{2, 5, 0, 0, 0, 0, 0, 0};
        issue(1, 1'b0, 15, 1'b1, got);
        check_eq("sp_const", 32'(got), 32'hE0);
        handshake(0, got);
        issue(1, 1'b1, 15, 1'b1, got);
        check_eq("sp_bias_const", 32'(got), 32'h1F);
        handshake(0, got);
        drw = '{15, 5, 0, 0, 0, 0, 0, 0};
        issue(1, 1'b0, 15, 1'b1, got);
        check_eq("sp_gate15", 32'(got), 32'h00);
        handshake(0, got);

        // Two-point
        drw = '{0, 6, 2, 0, 0, 0, 0, 0};
        issue(2, 1'b0, 15, 1'b1, got);
        check_eq("tp_const", 32'(got), 32'h3C);
        handshake(0, got);
        drw = '{0, 3, 3, 0, 0, 0, 0, 0};
        issue(2, 1'b0, 15, 1'b1, got);
        check_eq("tp_equal", 32'(got), 32'h00);
        handshake(0, got);

        // Pass with backpressure and ignored start pulses
        issue(3, 1'b1, 0, 1'b1, got);
        check_eq("pass_const", 32'(got), 32'hFF);
        for (int d = 0; d < 5; d++) begin
            start = d[0];
            mode  = 2'd0;
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_valid", 32'(mask_valid), 32'd1);
            check_eq("bp_mask", 32'(mask), 32'hFF);
        end
        start = 1'b0;
        handshake(0, got);

        // LFSR seed-of-zero and stepping
        @(negedge clk);
        seed_load = 1'b1; seed_in = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        seed_load = 1'b0;
        check_eq("seed_zero", 32'(dut.u_lfsr.state_o), 32'h0001);
        mlfsr = 16'h0001;
        issue(0, 1'b0, 9, 1'b0, got);
        check_eq("lfsr_8_steps", 32'(dut.u_lfsr.state_o), 32'(mlfsr));
        handshake(0, got);

        // Randomised requests with noise on start/seed_load while busy
        noise = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                seed_load = 1'b1;
                seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                @(posedge clk);
                mlfsr = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
                @(negedge clk);
                seed_load = 1'b0;
            end
            m   = int'($urandom_range(0, 3));
            b   = 1'($urandom_range(0, 1));
            p   = int'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) p = ($urandom_range(0, 1) != 0) ? 15 : 0;
            ext = 1'($urandom_range(0, 1));
            if (ext) for (int k = 0; k < 8; k++) drw[k] = int'($urandom_range(0, 15));
            issue(m, b, p, ext, got);
            handshake(int'($urandom_range(0, 3)), got);
            check_eq("rnd_lfsr", 32'(dut.u_lfsr.state_o), 32'(mlfsr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crossover_mask_gen.md
Name: crossover_mask_gen

Overview:
- Parametrised successor to the single-bit crossover selector in the GA datapath.
- Produces a GENES-wide crossover mask per request (1 = take gene from parent B, 0 = parent A) for the offspring assembly stage.
- Supports uniform, single-point and two-point crossover, gated by a crossover probability and an optional global bias inversion.
- Random source is an internal 16-bit LFSR, or an external random input for verification and for sharing a system RNG; results are returned over a valid/ready handshake.

Parameters:
- GENES, 8, mask width; must be a power of two, >=2.
- PROB_W, 4, width of prob and of each random draw; must be >= IDX_W.
- IDX_W, $clog2(GENES), gene index width (derived, not overridable).
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- mode  in  2  0=uniform, 1=single-point, 2=two-point, 3=pass (no crossover).
- bias  in  1  inverts the final mask when 1.
- prob  in  PROB_W  crossover probability threshold.
- rand_ext  in  1  1 = use rand_in instead of the LFSR, sampled per draw.
- rand_in  in  PROB_W  external random value.
- seed_load  in  1  load seed_in into the LFSR; honoured only in IDLE with start=0.
- seed_in  in  16  LFSR seed; value 0 loads 16'h0001.
- busy  out  1  high from accept until the mask handshake completes.
- mask_valid  out  1  mask is valid.
- mask_ready  in  1  consumer accepts the mask.
- mask  out  GENES  crossover mask.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, mask_valid=0, mask=0, LFSR=SEED, all internal registers cleared. Reset mid-operation aborts the request; no partial mask is ever presented.
- Accept: when state=IDLE and start=1, latch mode, bias and prob, then go to DRAW.
  - busy=1 from the next cycle.
  - start is ignored while busy.
- Draw rule: each DRAW cycle consumes one random r.
  - r = rand_in if rand_ext=1, else LFSR[PROB_W-1:0].
  - The LFSR advances one step only on cycles where it is consumed (Fibonacci, taps 16,14,13,11, shift-left, feedback into bit 0).
  - rand_in consumption does not advance the LFSR.
- Uniform (mode 0): GENES draws, gene index g=0..GENES-1 in order; raw[g] = (prob > r).
- Single-point (mode 1): 2 draws.
  - Draw 1 is the gate: crossover = (prob > r).
  - Draw 2 gives p = r[IDX_W-1:0].
  - raw[i] = crossover && (i >= p). p=0 gives all ones.
- Two-point (mode 2): 3 draws.
  - Gate, then a = r[IDX_W-1:0], then b = r[IDX_W-1:0].
  - lo = min(a,b), hi = max(a,b).
  - raw[i] = crossover && (lo <= i < hi). a==b gives all zeros.
- Pass (mode 3): 0 draws; raw = 0; goes straight to DONE.
- Gate boundaries: prob=0 never crosses over; prob = 2^PROB_W-1 crosses over unless r is all-ones. This is strict greater-than, identical to the legacy selector.
- DONE: mask = raw XOR {GENES{bias}}, mask_valid=1.
  - mask is held stable until mask_valid && mask_ready.
  - On that handshake cycle: state returns to IDLE, mask_valid and busy fall next cycle, and mask keeps its last value.
- Latency (accept edge to mask_valid=1):
  - uniform: GENES+1 cycles.
  - single-point: 3 cycles.
  - two-point: 4 cycles.
  - pass: 1 cycle.
- Back-to-back: a start asserted in the cycle after the handshake (busy=0) is accepted; throughput is one request per latency+1 cycles.
- seed_load together with start in IDLE: start wins and the seed is ignored. seed_load while busy: ignored.
- FSM: IDLE -> DRAW -> DONE -> IDLE; DRAW holds a draw counter of width IDX_W+1.

Decomposition:
- Shared package ga_pkg: mode encodings (XO_UNIFORM, XO_SINGLE, XO_TWO, XO_PASS), FSM state typedef, LFSR tap constant, default SEED.
- One sub-module: ga_lfsr16 (load, step enable, 16-bit state out), reused later by the mutation block.

Test Plan:
- Reset mid-uniform: GENES=8, mode=0, assert rst_n=0 in draw 4 -> mask_valid=0, mask=0, busy=0 immediately; the next request completes normally with latency 9.
- Uniform, external random: rand_ext=1, prob=8, rand_in sequence 0,9,7,8,15,1,8,3, bias=0 -> mask=8'b1010_0101 (bit0 first), mask_valid at cycle 9.
- Single-point: rand_ext=1, prob=15, draws 2 then 5, bias=0 -> mask=8'b1110_0000. Same with bias=1 -> 8'b0001_1111. Gate draw 15 -> mask=8'h00.
- Two-point: draws 0, 6, 2 -> mask=8'b0011_1100. Draws 0, 3, 3 -> mask=8'h00.
- Pass and backpressure: mode=3, bias=1 -> mask=8'hFF after 1 cycle. Hold mask_ready=0 for 5 cycles -> mask and mask_valid stable; start pulses ignored. Release -> busy low next cycle.
- LFSR: seed_load seed_in=0 -> state 16'h0001. Uniform request with rand_ext=0 -> mask matches the reference model, and the LFSR has advanced exactly 8 steps.
